// File: rtl/skid_pipe_register_pkg.sv
// Shared types and helpers for skid_pipe_register and its pipe_stage instances.
package skid_pipe_register_pkg;

  // Occupancy of one pipeline stage; the data word travels alongside it.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } stage_occ_e;

  // Counter width able to hold 0..DEPTH+1 (all stages plus the optional skid entry).
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data pipeline register: synchronous flush beats load; async reset loads RST_VAL.
module pipe_stage
  import skid_pipe_register_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  stage_occ_e       occ_q, occ_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    occ_d  = occ_q;
    data_d = data_q;
    if (flush) begin
      occ_d  = StEmpty;
      data_d = '0;
    end else if (load) begin
      occ_d  = in_valid ? StFull : StEmpty;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= StEmpty;
      data_q <= RST_VAL;
    end else begin
      occ_q  <= occ_d;
      data_q <= data_d;
    end
  end

  assign valid = (occ_q == StFull);
  assign data  = data_q;

endmodule

// File: rtl/skid_pipe_register.sv
// Valid/ready pipeline of DEPTH pipe_stage registers with same-cycle bubble collapse.
// Define SKID_PIPE_REGISTER_SKID_EN to add a one-entry input skid buffer with registered in_ready.
module skid_pipe_register
  import skid_pipe_register_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int unsigned     CNT_W   = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH:0]   stage_rdy;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             head_valid;
  logic [WIDTH-1:0] head_data;
  logic [CNT_W-1:0] stage_cnt;

  // Readiness ripples back from the output, so any hole lets every stage behind it advance.
  always_comb begin
    stage_rdy        = '0;
    stage_rdy[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      stage_rdy[k] = ~valid_q[k] | stage_rdy[k+1];
    end
  end

  assign load = {DEPTH{en}} & stage_rdy[DEPTH-1:0];

  always_comb begin
    src_valid    = '0;
    src_valid[0] = head_valid;
    src_data[0]  = head_data;
    for (int k = 1; k < int'(DEPTH); k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .flush    (flush),
      .in_valid (src_valid[k]),
      .in_data  (src_data[k]),
      .valid    (valid_q[k]),
      .data     (data_q[k])
    );
  end

  assign out_valid = valid_q[DEPTH-1] & en & ~flush;
  assign out_data  = data_q[DEPTH-1] & {WIDTH{~flush}};

  always_comb begin
    stage_cnt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      stage_cnt = stage_cnt + CNT_W'(valid_q[k]);
    end
  end

`ifdef SKID_PIPE_REGISTER_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             accept;

  // in_ready depends only on the skid register, cutting the path from out_ready and en.
  assign in_ready   = ~skid_valid_q & ~rst;
  assign accept     = in_valid & in_ready;
  assign head_valid = skid_valid_q | in_valid;
  assign head_data  = skid_valid_q ? skid_data_q : in_data;

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (skid_valid_q) begin
      if (load[0]) begin
        skid_valid_d = 1'b0;
      end
    end else if (accept && !load[0]) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= RST_VAL;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign count = stage_cnt + CNT_W'(skid_valid_q);
`else
  assign in_ready   = en & stage_rdy[0] & ~flush & ~rst;
  assign head_valid = in_valid;
  assign head_data  = in_data;
  assign count      = stage_cnt;
`endif

endmodule

// File: tb/tb_skid_pipe_register.sv
// Bench for skid_pipe_register (WIDTH=8, DEPTH=2): directed scenarios plus random traffic
// checked every cycle against a slot-level occupancy model; honours SKID_PIPE_REGISTER_SKID_EN.
module tb_skid_pipe_register;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned CW = $clog2(D + 2);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  skid_pipe_register #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Model: slot 0 is nearest the input, slot D-1 feeds the output; plus an optional skid word.
  bit           m_full [D];
  logic [W-1:0] m_data [D];
  bit           m_skid_full;
  logic [W-1:0] m_skid_data;

  task automatic chk(input string name, input int unsigned act, input int unsigned want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int stages_held();
    int n = 0;
    for (int k = 0; k < int'(D); k++) n += int'(m_full[k]);
    return n;
  endfunction

  function automatic int m_count();
    return stages_held() + int'(m_skid_full);
  endfunction

  function automatic bit exp_in_ready();
`ifdef SKID_PIPE_REGISTER_SKID_EN
    return !m_skid_full && !rst;
`else
    // A new word fits if there is a hole anywhere or the last word leaves this cycle.
    return en && !flush && !rst && (stages_held() < int'(D) || out_ready);
`endif
  endfunction

  task automatic model_clear();
    for (int k = 0; k < int'(D); k++) m_full[k] = 1'b0;
    m_skid_full = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && exp_in_ready();
    if (rst || flush) begin
      model_clear();
      return;
    end
    if (en) begin
      if (m_full[D-1] && out_ready) m_full[D-1] = 1'b0;
      for (int k = int'(D) - 1; k >= 1; k--) begin
        if (!m_full[k]) begin
          m_full[k]   = m_full[k-1];
          m_data[k]   = m_data[k-1];
          m_full[k-1] = 1'b0;
        end
      end
      if (!m_full[0]) begin
        if (m_skid_full) begin
          m_full[0]   = 1'b1;
          m_data[0]   = m_skid_data;
          m_skid_full = 1'b0;
        end else if (acc) begin
          m_full[0] = 1'b1;
          m_data[0] = in_data;
          acc       = 1'b0;
        end
      end
    end
    if (acc) begin
      m_skid_full = 1'b1;
      m_skid_data = in_data;
    end
  endtask

  always @(negedge clk) begin
    bit exp_ov;
    if (rst) model_clear();
    exp_ov = en && !flush && m_full[D-1];
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) chk("out_data", 32'(out_data), 32'(m_data[D-1]));
    chk("count", 32'(count), m_count());
    chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
    model_step();
  end

  task automatic drive(input bit v, input logic [W-1:0] d, input bit ordy, input bit e,
                       input bit fl);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    en        = e;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] got [$];
    logic [W-1:0] nxt;
    bit           acc;

    #1 rst = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_data", 32'(out_data), 32'h0000_00A5);
    rst = 1'b0;
    tick();

    // Streaming latency and throughput.
    for (int i = 0; i < 7; i++) begin
      drive(i < 5, 8'(i + 1), 1'b1, 1'b1, 1'b0);
      #1;
      if (i == 0) chk("lat_in_ready", 32'(in_ready), 1);
      if (i >= 2) begin
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'(i - 1));
      end
      tick();
    end

    // Fill under backpressure, then release.
    drive(1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'hA3, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fill_count", 32'(count), 2);
`ifdef SKID_PIPE_REGISTER_SKID_EN
    chk("fill_in_ready_skid", 32'(in_ready), 1);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
    chk("fill_count_skid", 32'(count), 3);
    chk("fill_model_count", m_count(), 3);
    chk("fill_in_ready_full", 32'(in_ready), 0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
`else
    chk("fill_in_ready", 32'(in_ready), 0);
    chk("fill_model_count", m_count(), 2);
    tick();
    drive(1'b1, 8'hA3, 1'b1, 1'b1, 1'b0);
`endif
    #1;
    chk("drain_a1", 32'(out_data), 32'hA1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    chk("drain_a2", 32'(out_data), 32'hA2);
    tick();
    #1;
    chk("drain_a3", 32'(out_data), 32'hA3);
    chk("drain_a3_valid", 32'(out_valid), 1);
    tick();

    // Bubble collapse: stage 1 full, stage 0 empty, output stalled.
    drive(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bubble_in_ready", 32'(in_ready), 1);
    chk("bubble_count_before", 32'(count), 1);
    chk("bubble_head", 32'(out_data), 32'h0F);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bubble_count", 32'(count), 2);
    chk("bubble_model_count", m_count(), 2);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    chk("bubble_out0", 32'(out_data), 32'h0F);
    tick();
    #1;
    chk("bubble_out1", 32'(out_data), 32'h10);
    tick();

    // Flush discards held and presented words.
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h44, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
    #1;
    chk("flush_count_before", 32'(count), 2);
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_data", 32'(out_data), 0);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_count", 32'(count), 0);
    chk("flush_valid_after", 32'(out_valid), 0);
    tick();
    tick();
    #1;
    chk("flush_count_later", 32'(count), 0);
    tick();

    // Asynchronous reset between edges with two words held.
    drive(1'b1, 8'h61, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 8'h62, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    #1;
    chk("arst_count_before", 32'(count), 2);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    #1;
    chk("arst_accept", 32'(in_ready), 1);
    tick();
    drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tick();
    #1;
    chk("arst_out_valid_77", 32'(out_valid), 1);
    chk("arst_out_77", 32'(out_data), 32'h77);
    tick();

    // Enable low for three cycles mid-stream: nothing lost or duplicated.
    nxt = 8'h81;
    for (int i = 0; i < 18; i++) begin
      drive(nxt <= 8'h88, nxt, 1'b1, !(i >= 3 && i <= 5), 1'b0);
      #1;
      if (!en) chk("stall_out_valid", 32'(out_valid), 0);
      if (out_valid && out_ready) got.push_back(out_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) nxt++;
    end
    chk("stall_len", got.size(), 8);
    for (int j = 0; j < got.size(); j++) chk("stall_word", 32'(got[j]), 32'h81 + j);

    // Random traffic with stalls, flushes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
